// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control sequencer.
package alu_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [4:0] OP_PASS = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_NEG  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [2:0] OP_SHIFT_PFX = 3'b010;
  localparam logic [4:0] OP_DIFF = 5'b10111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h01;

endpackage

// File: rtl/alu_ctrl_sequencer_decoder.sv
// Combinational instruction decoder: ALU select, destination and legality.
module alu_ctrl_decoder
  import alu_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [31:0]   instr,
  output logic [4:0]    opsel,
  output logic          ipsel,
  output logic [4:0]    dest,
  output logic          use_imm,
  output logic          illegal,
  output logic [DW-1:0] imm_ext
);

  logic [5:0] opcode;
  logic [4:0] funct;

  assign opcode  = instr[31:26];
  assign funct   = instr[4:0];
  assign imm_ext = {{(DW-16){instr[15]}}, instr[15:0]};

  always_comb begin
    opsel   = funct;
    ipsel   = 1'b0;
    dest    = instr[15:11];
    use_imm = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          OP_PASS, OP_ADD, OP_AND, OP_XOR, OP_DIFF: ;
          OP_NEG:  ipsel = 1'b1;
          default: if (funct[4:2] != OP_SHIFT_PFX) illegal = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        dest    = instr[20:16];
        opsel   = OP_ADD;
        use_imm = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Four-state sequencer feeding the ALU and writing results back to the register file.
// Optional zero_flag output enabled by defining ALU_CTRL_ZERO_FLAG_EN.
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = alu_ctrl_pkg::DATA_W,
  parameter int REG_AW = alu_ctrl_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_ipsel,
  output logic [4:0]        alu_opsel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              carry_flag,
`ifdef ALU_CTRL_ZERO_FLAG_EN
  output logic              zero_flag,
`endif
  output logic              illegal
);

  state_t              state;
  logic [31:0]         instr_q;
  logic [REG_AW-1:0]   dest_q;

  logic [31:0]         dec_instr;
  logic [4:0]          dec_opsel;
  logic                dec_ipsel;
  logic [4:0]          dec_dest;
  logic                dec_use_imm;
  logic                dec_illegal;
  logic [DATA_W-1:0]   dec_imm;

  // Decode the live word in IDLE so illegal can be flagged during DECODE.
  assign dec_instr = (state == IDLE) ? instr : instr_q;

  alu_ctrl_decoder #(.DW(DATA_W)) u_decoder (
    .instr   (dec_instr),
    .opsel   (dec_opsel),
    .ipsel   (dec_ipsel),
    .dest    (dec_dest),
    .use_imm (dec_use_imm),
    .illegal (dec_illegal),
    .imm_ext (dec_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_q     <= '0;
      dest_q      <= '0;
      instr_ready <= 1'b1;
      rs_addr     <= '0;
      rt_addr     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ipsel   <= 1'b0;
      alu_opsel   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      carry_flag  <= 1'b0;
`ifdef ALU_CTRL_ZERO_FLAG_EN
      zero_flag   <= 1'b0;
`endif
      illegal     <= 1'b0;
    end else begin
      illegal <= 1'b0;
      wr_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_q     <= instr;
            rs_addr     <= instr[25:21];
            rt_addr     <= instr[20:16];
            illegal     <= dec_illegal;
            instr_ready <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (dec_illegal) begin
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            alu_a     <= rs_data;
            alu_b     <= dec_use_imm ? dec_imm : rt_data;
            alu_opsel <= dec_opsel;
            alu_ipsel <= dec_ipsel;
            dest_q    <= dec_dest;
            state     <= EXEC;
          end
        end
        EXEC: begin
          wr_data <= alu_result;
          wr_addr <= dest_q;
          wr_en   <= (dest_q != '0);
          if (alu_opsel == OP_ADD) carry_flag <= alu_carry;
`ifdef ALU_CTRL_ZERO_FLAG_EN
          zero_flag <= (alu_result == '0);
`endif
          state   <= WB;
        end
        WB: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed bench for alu_ctrl_sequencer with a behavioural ALU and register file.
module tb_alu_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_a, alu_b;
  logic        alu_ipsel;
  logic [4:0]  alu_opsel;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        carry_flag;
  logic        illegal;
`ifdef ALU_CTRL_ZERO_FLAG_EN
  logic        zero_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  always_comb begin
    alu_carry  = 1'b0;
    alu_result = 32'h0;
    case (alu_opsel)
      5'b00000: alu_result = alu_a;
      5'b00001: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      5'b00010: alu_result = alu_a & alu_b;
      5'b00011: alu_result = alu_a ^ alu_b;
      5'b00101: alu_result = alu_ipsel ? (~alu_a + 32'd1) : alu_a;
      5'b10111: alu_result = alu_b - alu_a;
      default: begin
        if (alu_opsel[4:2] == 3'b010) begin
          if (alu_opsel[1])      alu_result = alu_a << alu_b[4:0];
          else if (alu_opsel[0]) alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
          else                   alu_result = alu_a >> alu_b[4:0];
        end
      end
    endcase
  end

  alu_ctrl_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ipsel   (alu_ipsel),
    .alu_opsel   (alu_opsel),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .carry_flag  (carry_flag),
`ifdef ALU_CTRL_ZERO_FLAG_EN
    .zero_flag   (zero_flag),
`endif
    .illegal     (illegal)
  );

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] funct);
    return {6'h00, rs, rt, rd, 6'b0, funct};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Handshake at edge N; returns at the falling edge inside cycle N+1 (DECODE).
  task automatic send(input logic [31:0] w);
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || wr_en !== 1'b0 || illegal !== 1'b0 || carry_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b wr_en=%b illegal=%b carry=%b, want 1 0 0 0",
               instr_ready, wr_en, illegal, carry_flag);
    end
    checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_opsel !== 5'h0 || alu_ipsel !== 1'b0 ||
        wr_addr !== 5'h0 || wr_data !== 32'h0 || rs_addr !== 5'h0 || rt_addr !== 5'h0) begin
      errors++;
      $display("FAIL reset_data: a=%h b=%h opsel=%b ipsel=%b waddr=%0d wdata=%h, want all 0",
               alu_a, alu_b, alu_opsel, alu_ipsel, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_r_add;
    regs[5] = 32'hFFFF_FFFF;
    regs[6] = 32'h1;
    send(mk_r(5'd5, 5'd6, 5'd7, 5'b00001));
    checks++;
    if (instr_ready !== 1'b0 || rs_addr !== 5'd5 || rt_addr !== 5'd6) begin
      errors++;
      $display("FAIL radd_decode: ready=%b rs=%0d rt=%0d, want 0 5 6", instr_ready, rs_addr, rt_addr);
    end
    @(negedge clk);
    checks++;
    if (alu_opsel !== 5'b00001 || alu_ipsel !== 1'b0 || alu_a !== 32'hFFFF_FFFF ||
        alu_b !== 32'h1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL radd_exec: opsel=%b ipsel=%b a=%h b=%h wr_en=%b, want 00001 0 ffffffff 1 0",
               alu_opsel, alu_ipsel, alu_a, alu_b, wr_en);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h0 || carry_flag !== 1'b1) begin
      errors++;
      $display("FAIL radd_wb: wr_en=%b addr=%0d data=%h carry=%b, want 1 7 0 1",
               wr_en, wr_addr, wr_data, carry_flag);
    end
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL radd_done: ready=%b wr_en=%b, want 1 0", instr_ready, wr_en);
    end
  endtask

  task automatic test_neg;
    regs[8] = 32'd3;
    send(mk_r(5'd8, 5'd0, 5'd9, 5'b00101));
    @(negedge clk);
    checks++;
    if (alu_opsel !== 5'b00101 || alu_ipsel !== 1'b1 || alu_a !== 32'd3) begin
      errors++;
      $display("FAIL neg_exec: opsel=%b ipsel=%b a=%h, want 00101 1 3", alu_opsel, alu_ipsel, alu_a);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'hFFFF_FFFD || carry_flag !== 1'b1) begin
      errors++;
      $display("FAIL neg_wb: wr_en=%b addr=%0d data=%h carry=%b, want 1 9 fffffffd 1",
               wr_en, wr_addr, wr_data, carry_flag);
    end
    @(negedge clk);
  endtask

  task automatic test_shift;
    regs[10] = 32'd4;
    send(mk_r(5'd8, 5'd10, 5'd15, 5'b01010));
    @(negedge clk);
    checks++;
    if (alu_opsel !== 5'b01010 || alu_ipsel !== 1'b0 || alu_b !== 32'd4) begin
      errors++;
      $display("FAIL shift_exec: opsel=%b ipsel=%b b=%h, want 01010 0 4", alu_opsel, alu_ipsel, alu_b);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd15 || wr_data !== 32'h30) begin
      errors++;
      $display("FAIL shift_wb: wr_en=%b addr=%0d data=%h, want 1 15 30", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
  endtask

  task automatic test_rd_zero;
    int writes = 0;
    regs[1] = 32'd1;
    regs[4] = 32'd2;
    send(mk_r(5'd1, 5'd4, 5'd0, 5'b00001));
    for (int i = 0; i < 4; i++) begin
      if (wr_en) writes++;
      @(negedge clk);
    end
    checks++;
    if (writes !== 0 || carry_flag !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_zero: writes=%0d carry=%b ready=%b, want 0 0 1", writes, carry_flag, instr_ready);
    end
  endtask

  task automatic test_addi;
    regs[2] = 32'd10;
    send(mk_i(6'h01, 5'd2, 5'd3, 16'hFFFE));
    @(negedge clk);
    checks++;
    if (alu_b !== 32'hFFFF_FFFE || alu_a !== 32'd10 || alu_opsel !== 5'b00001 || alu_ipsel !== 1'b0) begin
      errors++;
      $display("FAIL addi_exec: a=%h b=%h opsel=%b ipsel=%b, want a fffffffe 00001 0",
               alu_a, alu_b, alu_opsel, alu_ipsel);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'd8 || carry_flag !== 1'b1) begin
      errors++;
      $display("FAIL addi_wb: wr_en=%b addr=%0d data=%h carry=%b, want 1 3 8 1",
               wr_en, wr_addr, wr_data, carry_flag);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal(input logic [31:0] w);
    int writes = 0;
    send(w);
    checks++;
    if (illegal !== 1'b1 || instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse %h: illegal=%b ready=%b, want 1 0", w, illegal, instr_ready);
    end
    if (wr_en) writes++;
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0 || instr_ready !== 1'b1 || alu_opsel !== 5'b00001) begin
      errors++;
      $display("FAIL illegal_after %h: illegal=%b ready=%b opsel=%b, want 0 1 00001",
               w, illegal, instr_ready, alu_opsel);
    end
    for (int i = 0; i < 3; i++) begin
      if (wr_en) writes++;
      @(negedge clk);
    end
    checks++;
    if (writes !== 0) begin
      errors++;
      $display("FAIL illegal_nowrite %h: writes=%0d, want 0", w, writes);
    end
  endtask

  task automatic test_back_to_back;
    int hs = 0;
    int writes = 0;
    @(negedge clk);
    instr       = mk_r(5'd1, 5'd4, 5'd11, 5'b00001);
    instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready) hs++;
      if (wr_en) writes++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    checks++;
    if (hs !== 3 || writes !== 3) begin
      errors++;
      $display("FAIL back_to_back: handshakes=%0d writes=%0d, want 3 3", hs, writes);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int writes = 0;
    send(mk_r(5'd5, 5'd6, 5'd7, 5'b00001));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || wr_en !== 1'b0 || carry_flag !== 1'b0 || alu_opsel !== 5'h0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b wr_en=%b carry=%b opsel=%b, want 1 0 0 0",
               instr_ready, wr_en, carry_flag, alu_opsel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (wr_en) writes++;
      @(negedge clk);
    end
    checks++;
    if (writes !== 0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: writes=%0d ready=%b, want 0 1", writes, instr_ready);
    end
  endtask

`ifdef ALU_CTRL_ZERO_FLAG_EN
  task automatic test_zero_flag;
    regs[12] = 32'hF0;
    regs[13] = 32'h0F;
    send(mk_r(5'd12, 5'd13, 5'd14, 5'b00010));
    repeat (2) @(negedge clk);
    checks++;
    if (zero_flag !== 1'b1 || wr_data !== 32'h0 || wr_addr !== 5'd14) begin
      errors++;
      $display("FAIL zero_flag: zf=%b data=%h addr=%0d, want 1 0 14", zero_flag, wr_data, wr_addr);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_r_add();
    test_neg();
    test_shift();
    test_rd_zero();
    test_addi();
    test_illegal(mk_i(6'h3F, 5'd1, 5'd2, 16'h1234));
    test_illegal(mk_r(5'd1, 5'd2, 5'd3, 5'b11111));
    test_back_to_back();
`ifdef ALU_CTRL_ZERO_FLAG_EN
    test_zero_flag();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
